// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for a 16x8 program memory: PC/MAR, active-low output enable, IR and a
// valid/ready handoff to execute. Optional branch-on-handshake support under `FETCH_BRANCH_EN.
module fetch_sequencer #(
  parameter logic [3:0]  PC_RESET  = 4'h0,
  parameter logic [3:0]  HALT_OP   = 4'hF,
  parameter int unsigned READ_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [3:0] addr,
  output logic       low_o_en,
  output logic [3:0] op_code,
  output logic [3:0] operand,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] pc,
  output logic       halted
`ifdef FETCH_BRANCH_EN
  ,
  input  logic       jmp_en,
  input  logic [3:0] jmp_addr
`endif
);

  typedef enum logic [1:0] {
    ADDR  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(READ_WAIT);

  state_t     state;
  logic [1:0] wcnt;
  logic       handshake;

  assign handshake = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ADDR;
      pc          <= PC_RESET;
      addr        <= 4'h0;
      low_o_en    <= 1'b1;
      op_code     <= 4'h0;
      operand     <= 4'h0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      wcnt        <= 2'd0;
    end else begin
      case (state)
        ADDR: begin
          addr     <= pc;
          low_o_en <= 1'b0;
          wcnt     <= WAIT_INIT;
          state    <= READ;
        end
        READ: begin
          if (wcnt != 2'd0) begin
            wcnt <= wcnt - 2'd1;
          end else begin
            op_code     <= data_in[7:4];
            operand     <= data_in[3:0];
            low_o_en    <= 1'b1;
            pc          <= pc + 4'd1;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            if (op_code == HALT_OP) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              state <= ADDR;
`ifdef FETCH_BRANCH_EN
              // A taken jump replaces the PC that was already advanced at capture.
              if (jmp_en) pc <= jmp_addr;
`endif
            end
          end
        end
        HALT: begin
          low_o_en    <= 1'b1;
          instr_valid <= 1'b0;
        end
        default: state <= ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: three instances (default, PC_RESET=E, READ_WAIT=2) each with
// its own memory model; expected instructions/addresses are queued up front and popped on output.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] mem_a [16];
  logic [7:0] din_a;
  logic [3:0] addr_a, op_a, opr_a, pc_a;
  logic       oe_a, vld_a, rdy_a, hlt_a;
`ifdef FETCH_BRANCH_EN
  logic       jen;
  logic [3:0] jad;
`endif

  logic [7:0] mem_w [16];
  logic [7:0] din_w;
  logic [3:0] addr_w, op_w, opr_w, pc_w;
  logic       oe_w, vld_w, rdy_w, hlt_w;

  logic [7:0] mem_t [16];
  logic [7:0] din_t;
  logic [3:0] addr_t, op_t, opr_t, pc_t;
  logic       oe_t, vld_t, rdy_t, hlt_t;

  // Memory drives the bus only while enabled; otherwise a junk pattern.
  assign din_a = oe_a ? 8'h5A : mem_a[addr_a];
  assign din_w = oe_w ? 8'h5A : mem_w[addr_w];
  assign din_t = oe_t ? 8'h5A : mem_t[addr_t];

  fetch_sequencer u_dut (
    .clk(clk), .rst(rst), .data_in(din_a), .addr(addr_a), .low_o_en(oe_a),
    .op_code(op_a), .operand(opr_a), .instr_valid(vld_a), .instr_ready(rdy_a),
    .pc(pc_a), .halted(hlt_a)
`ifdef FETCH_BRANCH_EN
    , .jmp_en(jen), .jmp_addr(jad)
`endif
  );

  fetch_sequencer #(.PC_RESET(4'hE)) u_wrap (
    .clk(clk), .rst(rst), .data_in(din_w), .addr(addr_w), .low_o_en(oe_w),
    .op_code(op_w), .operand(opr_w), .instr_valid(vld_w), .instr_ready(rdy_w),
    .pc(pc_w), .halted(hlt_w)
`ifdef FETCH_BRANCH_EN
    , .jmp_en(1'b0), .jmp_addr(4'h0)
`endif
  );

  fetch_sequencer #(.READ_WAIT(2)) u_wait (
    .clk(clk), .rst(rst), .data_in(din_t), .addr(addr_t), .low_o_en(oe_t),
    .op_code(op_t), .operand(opr_t), .instr_valid(vld_t), .instr_ready(rdy_t),
    .pc(pc_t), .halted(hlt_t)
`ifdef FETCH_BRANCH_EN
    , .jmp_en(1'b0), .jmp_addr(4'h0)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  logic [3:0] addr_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] e8;
    logic [3:0] e4;
    logic [3:0] oe_pat;
    logic [3:0] vld_pat;

    rst = 1'b1;
    rdy_a = 1'b0; rdy_w = 1'b0; rdy_t = 1'b0;
`ifdef FETCH_BRANCH_EN
    jen = 1'b0; jad = 4'h0;
`endif
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'h00;
      mem_w[i] = 8'h11;
      mem_t[i] = 8'h00;
    end
    mem_a[0] = 8'h08; mem_a[1] = 8'h49; mem_a[2] = 8'hEE; mem_a[3] = 8'hFF;
    mem_t[0] = 8'h3C;

    @(negedge clk);
    tick();
    tick();

    // Reset state
    check("rst_addr", 32'(addr_a), 32'h0);
    check("rst_oe", 32'(oe_a), 32'h1);
    check("rst_op", 32'(op_a), 32'h0);
    check("rst_opr", 32'(opr_a), 32'h0);
    check("rst_vld", 32'(vld_a), 32'h0);
    check("rst_pc", 32'(pc_a), 32'h0);
    check("rst_hlt", 32'(hlt_a), 32'h0);
    check("rst_pc_wrap", 32'(pc_w), 32'hE);
    check("rst_addr_wrap", 32'(addr_w), 32'h0);
    check("rst_pc_wait", 32'(pc_t), 32'h0);
    check("rst_hlt_wait", 32'(hlt_t), 32'h0);

    // Backpressure on the first instruction, then full program to HLT
    exp_q.push_back(8'h08); exp_q.push_back(8'h49);
    exp_q.push_back(8'hEE); exp_q.push_back(8'hFF);
    rst = 1'b0;
    tick();
    check("fetch0_oe", 32'(oe_a), 32'h0);
    check("fetch0_addr", 32'(addr_a), 32'h0);
    tick();
    check("latency_vld", 32'(vld_a), 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("bp_op", 32'(op_a), 32'h0);
      check("bp_opr", 32'(opr_a), 32'h8);
      check("bp_pc", 32'(pc_a), 32'h1);
      check("bp_oe", 32'(oe_a), 32'h1);
      check("bp_vld", 32'(vld_a), 32'h1);
      tick();
    end
    rdy_a = 1'b1;
    e8 = exp_q.pop_front();
    check("instr", 32'({op_a, opr_a}), 32'(e8));
    tick();
    check("hs_vld_drop", 32'(vld_a), 32'h0);
    tick();
    check("next_addr", 32'(addr_a), 32'h1);
    check("next_oe", 32'(oe_a), 32'h0);
    for (int n = 0; n < 40 && !hlt_a; n++) begin
      if (vld_a) begin
        if (exp_q.size() != 0) begin
          e8 = exp_q.pop_front();
          check("instr", 32'({op_a, opr_a}), 32'(e8));
        end else begin
          check("instr_extra", 32'({op_a, opr_a}), 32'hFFFF);
        end
      end
      tick();
    end
    check("halted", 32'(hlt_a), 32'h1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_addr", 32'(addr_a), 32'h3);
      check("halt_oe", 32'(oe_a), 32'h1);
      check("halt_vld", 32'(vld_a), 32'h0);
      check("halt_pc", 32'(pc_a), 32'h4);
      check("halt_hold", 32'(hlt_a), 32'h1);
    end

    // Reset asserted mid-READ on the PC_RESET=E instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("midread_oe", 32'(oe_w), 32'h0);
    check("midread_addr", 32'(addr_w), 32'hE);
    rst = 1'b1;
    tick();
    check("rstread_oe", 32'(oe_w), 32'h1);
    check("rstread_vld", 32'(vld_w), 32'h0);
    check("rstread_pc", 32'(pc_w), 32'hE);
    check("rstread_addr", 32'(addr_w), 32'h0);
    rst = 1'b0;
    tick();
    check("restart_addr", 32'(addr_w), 32'hE);
    check("restart_oe", 32'(oe_w), 32'h0);

    // PC wrap: fetch addresses E,F,0,1
    addr_q.push_back(4'hE); addr_q.push_back(4'hF);
    addr_q.push_back(4'h0); addr_q.push_back(4'h1);
    rdy_w = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 10 && oe_w; n++) tick();
      check("wrap_oe_low", 32'(oe_w), 32'h0);
      e4 = addr_q.pop_front();
      check("wrap_addr", 32'(addr_w), 32'(e4));
      tick();
      check("wrap_vld", 32'(vld_w), 32'h1);
      check("wrap_pc", 32'(pc_w), 32'(4'(e4 + 4'd1)));
      check("wrap_instr", 32'({op_w, opr_w}), 32'h11);
      check("wrap_hlt", 32'(hlt_w), 32'h0);
    end

    // READ_WAIT=2 timing
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    oe_pat  = 4'b1000;
    vld_pat = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wait_oe", 32'(oe_t), 32'(oe_pat[k]));
      check("wait_vld", 32'(vld_t), 32'(vld_pat[k]));
      check("wait_addr", 32'(addr_t), 32'h0);
    end
    check("wait_instr", 32'({op_t, opr_t}), 32'h3C);

`ifdef FETCH_BRANCH_EN
    // Jump on handshake, then HLT with jmp_en high
    mem_a[10] = 8'hF3;
    rdy_a = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 10 && !vld_a; n++) tick();
    check("br_vld0", 32'(vld_a), 32'h1);
    tick();
    for (int n = 0; n < 10 && !vld_a; n++) tick();
    check("br_vld1", 32'(vld_a), 32'h1);
    check("br_pc1", 32'(pc_a), 32'h2);
    jen = 1'b1; jad = 4'hA;
    tick();
    jen = 1'b0;
    for (int n = 0; n < 10 && oe_a; n++) tick();
    check("br_addr", 32'(addr_a), 32'hA);
    tick();
    check("br_pc", 32'(pc_a), 32'hB);
    check("br_op", 32'(op_a), 32'hF);
    jen = 1'b1; jad = 4'h5;
    tick();
    jen = 1'b0;
    check("br_halt", 32'(hlt_a), 32'h1);
    check("br_halt_pc", 32'(pc_a), 32'hB);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
